// File: rtl/div_2_iterative_pkg.sv
// ---------------------------------------------------------------------------
// div_2_iterative_pkg
// Shared definitions for the iterative restoring divider:
//   state_e    - controller states (IDLE, BUSY, DONE)
//   rem_width  - width of the internal partial remainder (DATA_WIDTH + 1);
//                the extra bit holds the shifted remainder before the
//                compare/subtract so that no input can overflow it.
// ---------------------------------------------------------------------------
package div_2_iterative_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic int rem_width(input int data_width);
        return data_width + 1;
    endfunction

endpackage

// File: rtl/div_2_iterative_step.sv
// ---------------------------------------------------------------------------
// div_2_step
// One combinational restoring-division step.
//   rem_in       - partial remainder from the previous step (rem_width bits)
//   dividend_bit - next dividend bit, MSB first
//   divisor      - captured divisor (DATA_WIDTH bits)
//   rem_out      - partial remainder after the step
//   q_bit        - quotient bit produced by this step
// ---------------------------------------------------------------------------
module div_2_step
    import div_2_iterative_pkg::*;
#(
    parameter  int DATA_WIDTH = 2,
    localparam int RW         = rem_width(DATA_WIDTH)
) (
    input  logic [RW-1:0]         rem_in,
    input  logic                  dividend_bit,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic [RW-1:0]         rem_out,
    output logic                  q_bit
);

    logic [RW:0] shifted;
    logic [RW:0] divisor_ext;
    logic [RW:0] result;

    // The shift is carried one bit wider than the stored remainder so the
    // compare never truncates; the remainder always fits back into RW bits
    // because it is either below the divisor or, for a zero divisor, at
    // most the dividend.
    always_comb begin
        shifted     = {rem_in, dividend_bit};
        divisor_ext = {2'b00, divisor};
        q_bit       = 1'b0;
        result      = shifted;
        if (shifted >= divisor_ext) begin
            q_bit  = 1'b1;
            result = shifted - divisor_ext;
        end
        rem_out = RW'(result);
    end

endmodule

// File: rtl/div_2_iterative.sv
// ---------------------------------------------------------------------------
// div_2_iterative
// Unsigned iterative restoring divider, one quotient bit per clock, MSB
// first. Result appears DATA_WIDTH cycles after the accepting edge and is
// held until the consumer takes it.
//
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   in_valid / in_ready - operand handshake (ready only in IDLE)
//   a, b                - dividend and divisor, unsigned
//   out_valid/out_ready - result handshake (valid only in DONE)
//   quot                - floor(a/b); all ones when b is zero
//   rem                 - a mod b; a when b is zero
//                         (port exists only when DIV_2_ITERATIVE_REM_EN is
//                         defined; the remainder is computed either way)
//   div_by_zero         - captured divisor was zero
// ---------------------------------------------------------------------------
module div_2_iterative
    import div_2_iterative_pkg::*;
#(
    parameter int DATA_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] quot,
`ifdef DIV_2_ITERATIVE_REM_EN
    output logic [DATA_WIDTH-1:0] rem,
`endif
    output logic                  div_by_zero
);

    localparam int RW = rem_width(DATA_WIDTH);
    localparam int CW = $clog2(DATA_WIDTH);

    state_e                state_q, state_d;
    logic [CW-1:0]         count_q, count_d;
    logic [DATA_WIDTH-1:0] a_q, a_d;
    logic [DATA_WIDTH-1:0] b_q, b_d;
    logic [DATA_WIDTH-1:0] quot_q, quot_d;
    logic [RW-1:0]         rem_q, rem_d;
    logic                  dbz_q, dbz_d;

    logic [RW-1:0]         step_rem;
    logic                  step_q_bit;
    logic                  accept;

    div_2_step #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_step (
        .rem_in       (rem_q),
        .dividend_bit (a_q[count_q]),
        .divisor      (b_q),
        .rem_out      (step_rem),
        .q_bit        (step_q_bit)
    );

    always_comb begin
        in_ready  = (state_q == ST_IDLE);
        out_valid = (state_q == ST_DONE);
        accept    = in_valid && in_ready;
    end

    // The counter indexes the dividend bit consumed this cycle, so the step
    // at count zero is the last one and moves straight to DONE.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        a_d     = a_q;
        b_d     = b_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    a_d     = a;
                    b_d     = b;
                    quot_d  = '0;
                    rem_d   = '0;
                    dbz_d   = (b == '0);
                    count_d = CW'(DATA_WIDTH - 1);
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                rem_d  = step_rem;
                quot_d = {quot_q[DATA_WIDTH-2:0], step_q_bit};
                if (count_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    count_d = count_q - CW'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            a_q     <= a_d;
            b_q     <= b_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    always_comb begin
        quot        = quot_q;
        div_by_zero = dbz_q;
    end

`ifdef DIV_2_ITERATIVE_REM_EN
    always_comb begin
        rem = rem_q[DATA_WIDTH-1:0];
    end
`endif

endmodule

// File: doc/div_2_iterative.md
DIV_2_ITERATIVE -- requirements
Module: div_2_iterative

Interface
REQ-001 Parameter DATA_WIDTH, default 2; operand and result width in bits; legal range 2..32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 in_valid  input  1  operand pair on a/b is valid.
REQ-005 in_ready  output  1  block can accept an operand pair.
REQ-006 a  input  DATA_WIDTH  dividend, unsigned.
REQ-007 b  input  DATA_WIDTH  divisor, unsigned.
REQ-008 out_valid  output  1  result on quot/rem/div_by_zero is valid.
REQ-009 out_ready  input  1  consumer accepts the result.
REQ-010 quot  output  DATA_WIDTH  quotient floor(a/b).
REQ-011 rem  output  DATA_WIDTH  remainder a mod b; present only with DIV_2_ITERATIVE_REM_EN.
REQ-012 div_by_zero  output  1  captured b was zero.

Function
REQ-013 FSM states IDLE, BUSY, DONE; reset state IDLE.
REQ-014 in_ready SHALL be 1 exactly when state is IDLE; accept = in_valid && in_ready.
REQ-015 On accept: capture a and b, clear partial remainder, load bit counter with DATA_WIDTH-1, go to BUSY.
REQ-016 BUSY: one restoring step per cycle, MSB first: shift remainder left, bring in next dividend bit, subtract b if remainder >= b, set quotient bit accordingly.
REQ-017 Counter 0 in BUSY: perform final step, go to DONE; out_valid first seen high exactly DATA_WIDTH cycles after the accept edge.
REQ-018 Internal remainder/compare width DATA_WIDTH+1 bits; no overflow or truncation for any input.
REQ-019 DONE: out_valid=1; quot, rem, div_by_zero held stable while out_ready=0 (unbounded backpressure).
REQ-020 DONE and out_ready=1: go to IDLE next edge; in_ready=0 in DONE, so no accept in the same cycle as result handoff.
REQ-021 b=0: same latency; quot = all ones, rem = a, div_by_zero=1; otherwise div_by_zero=0.
REQ-022 a and b changes after accept SHALL NOT affect the in-flight result.
REQ-023 in_valid while BUSY or DONE ignored; no queuing.

Reset
REQ-024 rst asserted: state=IDLE, out_valid=0, quot=0, rem=0, div_by_zero=0, counter=0, asynchronously.
REQ-025 rst mid-operation abandons the operation; no result produced afterward.
REQ-026 in_ready=1 on the first clock edge after rst deasserts.

Configuration
REQ-027 Macro DIV_2_ITERATIVE_REM_EN defined: rem port present and driven per REQ-010/021.
REQ-028 Macro undefined: rem port absent; remainder still computed internally; quot, div_by_zero, timing identical.

Structure
REQ-029 Package div_2_iterative_pkg holds the FSM state enum and the DATA_WIDTH+1 remainder width constant function.
REQ-030 One sub-module div_2_step: combinational single restoring step (remainder in, dividend bit, divisor -> remainder out, quotient bit).

Verification
REQ-031 DATA_WIDTH=2, a=3 b=1 -> after 2 cycles quot=3 rem=0 div_by_zero=0.
REQ-032 a=3 b=2 -> quot=1 rem=1; a=2 b=3 -> quot=0 rem=2.
REQ-033 a=1 b=0 -> quot=3 rem=1 div_by_zero=1, latency 2.
REQ-034 out_ready held 0 for 5 cycles in DONE -> outputs stable, in_ready=0; out_ready=1 -> IDLE next edge, back-to-back accept next cycle.
REQ-035 rst pulse one cycle after accept -> out_valid never rises; next op a=2 b=1 -> quot=2 rem=0.
REQ-036 DATA_WIDTH=8, a=200 b=7 -> quot=28 rem=4 after 8 cycles; build without macro -> quot unchanged.
